univ_shift_reg: RTL and testbench

//  Parametrised universal storage register: hold / parallel load / shift left / shift right,

---
 rtl/shift_reg_pkg.sv | 19 +
 rtl/univ_shift_reg_if.sv | 39 +++
 rtl/shift_burst_ctrl.sv | 83 ++++++++
 rtl/univ_shift_reg.sv | 84 ++++++++
 tb/tb_univ_shift_reg.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: mode codes, shift directions
// and the burst controller state type.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } burst_state_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of univ_shift_reg. The clr member exists only when
// SYNC_CLEAR_EN is defined.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             burst_start;
  logic             burst_dir;
  logic [CNT_W-1:0] burst_len;
`ifdef SYNC_CLEAR_EN
  logic             clr;
`endif
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, sin, burst_start, burst_dir, burst_len,
`ifdef SYNC_CLEAR_EN
    output clr,
`endif
    input  q, sout, busy, done
  );

  modport slave (
    input  en, mode, d, sin, burst_start, burst_dir, burst_len,
`ifdef SYNC_CLEAR_EN
    input  clr,
`endif
    output q, sout, busy, done
  );

endinterface

// File: rtl/shift_burst_ctrl.sv
// Burst-shift sequencer: IDLE/SHIFT/DONE FSM with a clamped down-counter.
// Issues one shift request per cycle in SHIFT and a one-cycle done afterwards.
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             burst_start,
  input  logic             burst_dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic             idle,
  output logic             accept,
  output logic             busy,
  output logic             done,
  output logic             shift_req,
  output logic             shift_dir
);

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(WIDTH);

  burst_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (burst_len > MaxLen) ? MaxLen : burst_len;
  assign shift_dir   = dir_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    idle      = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    shift_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        idle = 1'b1;
        if (burst_start && !clr) begin
          accept  = 1'b1;
          dir_d   = burst_dir;
          cnt_d   = len_clamped;
          state_d = (len_clamped == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        busy      = 1'b1;
        shift_req = !clr;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear wins over everything; an aborted burst never reaches DONE.
    if (clr) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal storage register (hold/load/shift left/shift right) with an autonomous
// burst-shift engine. Define SYNC_CLEAR_EN to add the synchronous clr input.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             clr;
  logic             idle, accept, shift_req, shift_dir;
  logic [WIDTH-1:0] q_shl, q_shr;

`ifdef SYNC_CLEAR_EN
  assign clr = bus.clr;
`else
  assign clr = 1'b0;
`endif

  shift_burst_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .burst_start(bus.burst_start),
    .burst_dir  (bus.burst_dir),
    .burst_len  (bus.burst_len),
    .idle       (idle),
    .accept     (accept),
    .busy       (bus.busy),
    .done       (bus.done),
    .shift_req  (shift_req),
    .shift_dir  (shift_dir)
  );

  assign q_shl = {q_q[WIDTH-2:0], bus.sin};
  assign q_shr = {bus.sin, q_q[WIDTH-1:1]};

  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    if (clr) begin
      q_d = '0;
    end else if (shift_req) begin
      q_d = (shift_dir == DIR_LEFT) ? q_shl : q_shr;
    end else if (accept) begin
      // Accept edge only latches direction; data waits for the first shift.
      dir_d = bus.burst_dir;
    end else if (idle && bus.en) begin
      unique case (bus.mode)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = bus.d;
        MODE_SHL: begin
          q_d   = q_shl;
          dir_d = DIR_LEFT;
        end
        MODE_SHR: begin
          q_d   = q_shr;
          dir_d = DIR_RIGHT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = (dir_q == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): behavioural model checked every
// cycle plus directed literal checks.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic clr_v;
`ifdef SYNC_CLEAR_EN
  assign clr_v = bus.clr;
`else
  assign clr_v = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp8(input int l);
    return (l > 8) ? 8 : l;
  endfunction

  // Behavioural model: remaining-shift count plus a pending-done flag.
  logic [7:0] m_q;
  logic       m_dir, m_busy, m_done;
  int         m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 8'h00; m_dir <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (clr_v) begin
        m_q <= 8'h00; m_busy <= 1'b0; m_rem <= 0;
      end else if (m_busy) begin
        m_q   <= m_dir ? {bus.sin, m_q[7:1]} : {m_q[6:0], bus.sin};
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end
      end else if (!m_done) begin
        if (bus.burst_start) begin
          m_dir <= bus.burst_dir;
          if (clamp8(int'(bus.burst_len)) == 0) m_done <= 1'b1;
          else begin
            m_busy <= 1'b1; m_rem <= clamp8(int'(bus.burst_len));
          end
        end else if (bus.en) begin
          case (bus.mode)
            2'b01: m_q <= bus.d;
            2'b10: begin m_q <= {m_q[6:0], bus.sin}; m_dir <= 1'b0; end
            2'b11: begin m_q <= {bus.sin, m_q[7:1]}; m_dir <= 1'b1; end
            default: m_q <= m_q;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_q", {24'h0, bus.q}, {24'h0, m_q});
    check("model_sout", {31'h0, bus.sout}, {31'h0, (m_dir ? m_q[0] : m_q[7])});
    check("model_busy", {31'h0, bus.busy}, {31'h0, m_busy});
    check("model_done", {31'h0, bus.done}, {31'h0, m_done});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0; bus.mode = 2'b00; bus.d = 8'h00; bus.sin = 1'b0;
    bus.burst_start = 1'b0; bus.burst_dir = 1'b0; bus.burst_len = 4'd0;
`ifdef SYNC_CLEAR_EN
    bus.clr = 1'b0;
`endif
  endtask

  task automatic load(input logic [7:0] v);
    bus.en = 1'b1; bus.mode = 2'b01; bus.d = v;
    step();
    bus.en = 1'b0; bus.mode = 2'b00;
  endtask

  task automatic start_burst(input logic dir, input logic [3:0] len);
    bus.burst_start = 1'b1; bus.burst_dir = dir; bus.burst_len = len;
    step();
    bus.burst_start = 1'b0;
  endtask

  int nb, nd;

  initial begin
    idle_inputs();
    #1;
    check("reset_q", {24'h0, bus.q}, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    #20;
    rst_n = 1'b1;
    step();

    // Load, then disabled load must hold.
    load(8'hA5);
    check("load_a5", {24'h0, bus.q}, 32'hA5);
    bus.en = 1'b0; bus.mode = 2'b01; bus.d = 8'hFF;
    step();
    check("hold_en0", {24'h0, bus.q}, 32'hA5);

    // Shift left then right; sout follows last direction.
    bus.en = 1'b1; bus.mode = 2'b10; bus.sin = 1'b1;
    step();
    check("shl", {24'h0, bus.q}, 32'h4B);
    bus.mode = 2'b11; bus.sin = 1'b0;
    step();
    check("shr", {24'h0, bus.q}, 32'h25);
    check("sout_right", {31'h0, bus.sout}, 32'h1);
    idle_inputs();

    // Burst right by 3 from 81; a start pulse while busy must be ignored.
    load(8'h81);
    start_burst(1'b1, 4'd3);
    check("accept_q", {24'h0, bus.q}, 32'h81);
    nb = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy) nb++;
      if (bus.done) nd++;
      bus.burst_start = (i == 1);
      bus.burst_dir = 1'b1; bus.burst_len = 4'd3;
      step();
    end
    idle_inputs();
    check("burst3_busy_cycles", nb, 3);
    check("burst3_done_cycles", nd, 1);
    check("burst3_q", {24'h0, bus.q}, 32'h10);

    // Zero-length burst: done next cycle, no busy, q unchanged.
    start_burst(1'b0, 4'd0);
    check("len0_done_next", {31'h0, bus.done}, 32'h1);
    nb = 0; nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy) nb++;
      if (bus.done) nd++;
      step();
    end
    check("len0_busy_cycles", nb, 0);
    check("len0_done_cycles", nd, 1);
    check("len0_q", {24'h0, bus.q}, 32'h10);

    // Over-length burst clamps to 8 shifts.
    load(8'hFF);
    start_burst(1'b0, 4'd12);
    nb = 0; nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.busy) nb++;
      if (bus.done) nd++;
      step();
    end
    check("len12_busy_cycles", nb, 8);
    check("len12_done_cycles", nd, 1);
    check("len12_q", {24'h0, bus.q}, 32'h00);

    // Async reset mid-burst clears without a clock edge.
    load(8'h5A);
    start_burst(1'b0, 4'd5);
    step();
    check("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", {24'h0, bus.q}, 32'h0);
    check("async_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("async_rst_done", {31'h0, bus.done}, 32'h0);
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) nd++;
      step();
    end
    check("rst_no_done", nd, 0);

`ifdef SYNC_CLEAR_EN
    // Clear during the second shift of a 5-shift burst aborts it.
    load(8'hC3);
    start_burst(1'b0, 4'd5);
    step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("clr_q", {24'h0, bus.q}, 32'h0);
    check("clr_busy", {31'h0, bus.busy}, 32'h0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) nd++;
      step();
    end
    check("clr_no_done", nd, 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
